// File: rtl/mac_rx_pkg.sv
// mac_rx_pkg: shared widths, FSM encoding, status-word layout and the serial FCS step for the enet MAC.
package mac_rx_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 14;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned LEN_W  = 12;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] FCS_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_DATA, S_FLUSH, S_STATUS, S_FULL, S_DROP
  } rx_state_e;

  // Buffer word 0 layout written at end of frame
  typedef struct packed {
    logic [12:0]      rsvd_hi;
    logic             runt;
    logic             align_err;
    logic             fcs_ok;
    logic [3:0]       rsvd_lo;
    logic [LEN_W-1:0] len;
  } rx_status_t;

  // One bit of the Ethernet FCS shift register, bits fed in wire order
  function automatic logic [31:0] fcs32_1(input logic din, input logic [31:0] crc);
    fcs32_1 = {crc[30:0], 1'b0} ^ ((crc[31] ^ din) ? CRC_POLY : 32'h0);
  endfunction

  // Reorder a MAC address (first octet in the MSBs) into on-the-wire bit order
  function automatic logic [47:0] mac_to_stream(input logic [47:0] mac);
    mac_to_stream = '0;
    for (int i = 0; i < 6; i++) mac_to_stream[8*i +: 8] = mac[40-8*i +: 8];
  endfunction

endpackage

// File: rtl/mac_rx_if.sv
// mac_rx_if: PLS bit stream, RX buffer write port and CPU handshake of the MAC receiver.
interface mac_rx_if;
  logic                          rx_dv;
  logic                          rx_bit;
  logic                          rx_bit_stb;
  logic                          rx_ack;
  logic                          buf_we;
  logic [mac_rx_pkg::ADDR_W-1:0] buf_addr;
  logic [mac_rx_pkg::DATA_W-1:0] buf_wdata;
  logic                          rxfull;
  logic [mac_rx_pkg::DROP_W-1:0] rx_drop_cnt;

  modport master (
    output rx_dv, rx_bit, rx_bit_stb, rx_ack,
    input  buf_we, buf_addr, buf_wdata, rxfull, rx_drop_cnt
  );

  modport slave (
    input  rx_dv, rx_bit, rx_bit_stb, rx_ack,
    output buf_we, buf_addr, buf_wdata, rxfull, rx_drop_cnt
  );
endinterface

// File: rtl/mac_rx_crc32.sv
// mac_rx_crc32: serial Ethernet CRC register with init, per-bit step and residue match.
module mac_rx_crc32
  import mac_rx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic init,
  input  logic step,
  input  logic din,
  output logic match_c
);

  logic [31:0] crc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (step) crc <= fcs32_1(din, crc);
  end

  assign match_c = (crc == FCS_RESIDUE);

endmodule

// File: rtl/mac_rx.sv
// mac_rx: 10BASE-T MAC receive path -- SFD hunt, LSB-first word packing, FCS check, status word, rxfull.
// Optional destination-address filtering against STATION_MAC with `define MAC_RX_ADDR_FILTER_EN.
module mac_rx
  import mac_rx_pkg::*;
#(
  parameter int unsigned BUF_WORDS   = 512,
`ifdef MAC_RX_ADDR_FILTER_EN
  parameter logic [47:0] STATION_MAC = 48'h0200_0000_0001,
`endif
  parameter int unsigned MIN_BYTES   = 64
) (
  input logic     clk_i,
  input logic     rst_i,
  mac_rx_if.slave bus
);

  localparam int unsigned BYTE_W = CNT_W - 3;

  rx_state_e         state, state_nxt;
  logic [CNT_W-1:0]  bitcnt;
  logic [DATA_W-1:0] word_reg;
  logic              prev_bit;
  logic              dv_q;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              rxfull;
  logic [DROP_W-1:0] drop_cnt;

  logic              stb_c, overflow_c, reject_c, drop_inc_c, crc_init_c, crc_match_c;
  logic [BYTE_W-1:0] bytes_c;
  rx_status_t        status_c;

  assign stb_c      = (state == S_DATA) && bus.rx_bit_stb;
  // First bit of a word that would land beyond the last buffer address
  assign overflow_c = stb_c && (bitcnt[CNT_W-1:5] == ADDR_W'(BUF_WORDS - 1));
  assign crc_init_c = (state == S_IDLE) || (state == S_HUNT);
  assign drop_inc_c = overflow_c || reject_c ||
                      (bus.rx_dv && !dv_q && (state inside {S_FLUSH, S_STATUS, S_FULL}));

`ifdef MAC_RX_ADDR_FILTER_EN
  localparam logic [47:0] STATION_STREAM = mac_to_stream(STATION_MAC);
  logic [46:0] da_reg;
  logic [47:0] da_c;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                 da_reg <= '0;
    else if (stb_c && (bitcnt < CNT_W'(47)))    da_reg <= {bus.rx_bit, da_reg[46:1]};
  end

  // Decide on the 48th DA bit: own address, broadcast or group (I/G) address passes
  assign da_c     = {bus.rx_bit, da_reg};
  assign reject_c = stb_c && (bitcnt == CNT_W'(47)) &&
                    (da_c != STATION_STREAM) && !(&da_c) && !da_c[0];
`else
  assign reject_c = 1'b0;
`endif

  mac_rx_crc32 u_crc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .init    (crc_init_c),
    .step    (stb_c),
    .din     (bus.rx_bit),
    .match_c (crc_match_c)
  );

  always_comb begin
    status_c           = '0;
    bytes_c            = bitcnt[CNT_W-1:3];
    if (bytes_c >= BYTE_W'(4)) status_c.len = LEN_W'(bytes_c - BYTE_W'(4));
    status_c.fcs_ok    = crc_match_c;
    status_c.align_err = |bitcnt[2:0];
    status_c.runt      = bytes_c < BYTE_W'(MIN_BYTES);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.rx_dv) state_nxt = S_HUNT;
      S_HUNT:   if (!bus.rx_dv) state_nxt = S_IDLE;
                else if (bus.rx_bit_stb && prev_bit && bus.rx_bit) state_nxt = S_DATA;
      S_DATA:   if (overflow_c || reject_c) state_nxt = S_DROP;
                else if (!bus.rx_dv) state_nxt = S_FLUSH;
      S_FLUSH:  state_nxt = S_STATUS;
      S_STATUS: state_nxt = S_FULL;
      S_FULL:   if (bus.rx_ack) state_nxt = bus.rx_dv ? S_DROP : S_IDLE;
      S_DROP:   if (!bus.rx_dv) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      bitcnt    <= '0;
      word_reg  <= '0;
      prev_bit  <= 1'b0;
      dv_q      <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      rxfull    <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state  <= state_nxt;
      dv_q   <= bus.rx_dv;
      buf_we <= 1'b0;
      if (drop_inc_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
      unique case (state)
        S_HUNT: begin
          bitcnt   <= '0;
          word_reg <= '0;
          if (bus.rx_bit_stb) prev_bit <= bus.rx_bit;
        end
        S_DATA: if (stb_c && !overflow_c && !reject_c) begin
          bitcnt <= bitcnt + CNT_W'(1);
          if (bitcnt[4:0] == 5'd31) begin
            buf_we    <= 1'b1;
            buf_addr  <= bitcnt[CNT_W-1:5] + ADDR_W'(1);
            buf_wdata <= {bus.rx_bit, word_reg[30:0]};
            word_reg  <= '0;
          end else begin
            word_reg[bitcnt[4:0]] <= bus.rx_bit;
          end
        end
        S_FLUSH: if (bitcnt[4:0] != 5'd0) begin
          buf_we    <= 1'b1;
          buf_addr  <= bitcnt[CNT_W-1:5] + ADDR_W'(1);
          buf_wdata <= word_reg;
        end
        S_STATUS: begin
          buf_we    <= 1'b1;
          buf_addr  <= '0;
          buf_wdata <= status_c;
          rxfull    <= 1'b1;
        end
        S_FULL: if (bus.rx_ack) rxfull <= 1'b0;
        default: prev_bit <= 1'b0;
      endcase
    end
  end

  assign bus.buf_we      = buf_we;
  assign bus.buf_addr    = buf_addr;
  assign bus.buf_wdata   = buf_wdata;
  assign bus.rxfull      = rxfull;
  assign bus.rx_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_mac_rx.sv
// tb_mac_rx: directed frames with hand-computed status words and buffer contents for mac_rx.
module tb_mac_rx;

  localparam logic [47:0] STA = 48'h0200_0000_0001;
`ifdef MAC_RX_ADDR_FILTER_EN
  localparam logic [7:0] DROPS_T6 = 8'd3;
`else
  localparam logic [7:0] DROPS_T6 = 8'd2;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_chk = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   addr0_cnt = 0;
  int   base, base0;
  logic [31:0] mem [0:511];
  logic bits [$];

  always #25 clk_i = ~clk_i;

  mac_rx_if bus ();

  mac_rx dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Buffer RAM model fed by the write port
  always @(negedge clk_i) begin
    if (bus.buf_we === 1'b1) begin
      mem[bus.buf_addr] = bus.buf_wdata;
      wr_cnt++;
      if (bus.buf_addr == 9'd0) addr0_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    logic fb;
    fb = c[31] ^ b;
    crc_bit = {c[30:0], 1'b0};
    if (fb) crc_bit = crc_bit ^ 32'h04C1_1DB7;
  endfunction

  // Frame bits after the SFD: DA, pattern bytes, complemented FCS (MSB first), optional dribble
  task automatic build(input int nbytes, input logic [47:0] da, input int flip,
                       input int ndrib, input logic [2:0] drib);
    logic [31:0] c;
    logic [7:0]  by;
    bits.delete();
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < nbytes; k++) begin
      by = (k < 6) ? da[47-8*k -: 8] : 8'(k*7+3);
      for (int j = 0; j < 8; j++) begin
        bits.push_back(by[j]);
        c = crc_bit(c, by[j]);
      end
    end
    for (int i = 31; i >= 0; i--) bits.push_back(~c[i]);
    if (flip >= 0) bits[flip] = ~bits[flip];
    for (int i = 0; i < ndrib; i++) bits.push_back(drib[i]);
  endtask

  function automatic logic [31:0] exp_word(input int idx);
    exp_word = '0;
    for (int j = 0; j < 32; j++)
      if (32*idx + j < bits.size()) exp_word[j] = bits[32*idx + j];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap, input logic fall);
    bus.rx_bit     = b;
    bus.rx_bit_stb = 1'b1;
    if (fall) bus.rx_dv = 1'b0;
    step();
    bus.rx_bit_stb = 1'b0;
    repeat (gap) step();
  endtask

  // mode 0: rx_dv falls after the last bit, 1: with the last strobe, 2: rx_dv left high
  task automatic drive(input int gap, input int limit, input int mode);
    int n;
    n = (limit < bits.size()) ? limit : bits.size();
    bus.rx_dv = 1'b1;
    step();
    step();
    for (int i = 0; i < 64; i++) send_bit((i == 63) || (i % 2 == 0), gap, 1'b0);
    for (int i = 0; i < n; i++) send_bit(bits[i], gap, (mode == 1) && (i == n - 1));
    if (mode != 2) begin
      bus.rx_dv = 1'b0;
      step();
    end
  endtask

  task automatic wait_full(input string tag);
    int t;
    t = 0;
    while ((bus.rxfull !== 1'b1) && (t < 20)) begin
      step();
      t++;
    end
    if (t >= 20) begin
      n_fail++;
      $error("FAIL %s: rxfull wait expired after %0d cycles", tag, t);
    end
    step();
    chk(tag, 32'(bus.rxfull), 32'd1);
  endtask

  task automatic ack(input string tag);
    bus.rx_ack = 1'b1;
    step();
    bus.rx_ack = 1'b0;
    chk(tag, 32'(bus.rxfull), 32'd0);
  endtask

  initial begin
    bus.rx_dv = 1'b0; bus.rx_bit = 1'b0; bus.rx_bit_stb = 1'b0; bus.rx_ack = 1'b0;
    rst_i = 1'b0;
    repeat (3) step();
    chk("rst_rxfull", 32'(bus.rxfull), 32'd0);
    chk("rst_buf_we", 32'(bus.buf_we), 32'd0);
    chk("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
    chk("rst_buf_wdata", bus.buf_wdata, 32'd0);
    chk("rst_drop_cnt", 32'(bus.rx_drop_cnt), 32'd0);
    rst_i = 1'b1;
    step();

    // 64-byte frame, good FCS
    build(60, STA, -1, 0, 3'b000);
    base = wr_cnt;
    drive(1, 100000, 0);
    wait_full("t1_rxfull");
    chk("t1_writes", 32'(wr_cnt - base), 32'd17);
    for (int w = 0; w < 16; w++) chk("t1_word", mem[w+1], exp_word(w));
    chk("t1_status", mem[0], 32'h0001_003C);
    ack("t1_ack");

    // Same frame with one payload bit flipped
    build(60, STA, 100, 0, 3'b000);
    base = wr_cnt;
    drive(1, 100000, 0);
    wait_full("t2_rxfull");
    chk("t2_writes", 32'(wr_cnt - base), 32'd17);
    chk("t2_word3", mem[4], exp_word(3));
    chk("t2_status", mem[0], 32'h0000_003C);
    ack("t2_ack");

    // 20-byte runt with three dribble bits
    build(16, STA, -1, 3, 3'b101);
    base = wr_cnt;
    drive(1, 100000, 0);
    wait_full("t3_rxfull");
    chk("t3_writes", 32'(wr_cnt - base), 32'd7);
    chk("t3_word1", mem[1], exp_word(0));
    chk("t3_partial", mem[6], 32'h0000_0005);
    chk("t3_status", mem[0] & 32'hFFFE_FFFF, 32'h0006_0010);

    // Frame arriving while the buffer is still full
    build(60, STA, -1, 0, 3'b000);
    base = wr_cnt;
    drive(1, 100000, 0);
    repeat (5) step();
    chk("t4_writes", 32'(wr_cnt - base), 32'd0);
    chk("t4_drop_cnt", 32'(bus.rx_drop_cnt), 32'd1);
    chk("t4_rxfull", 32'(bus.rxfull), 32'd1);
    chk("t4_word0", mem[0] & 32'hFFFE_FFFF, 32'h0006_0010);
    ack("t4_ack");

    // Oversize frame: 511 words fit, the 512th triggers drop
    build(2042, STA, -1, 0, 3'b000);
    base = wr_cnt;
    base0 = addr0_cnt;
    drive(0, 100000, 0);
    repeat (5) step();
    chk("t5_writes", 32'(wr_cnt - base), 32'd511);
    chk("t5_no_status", 32'(addr0_cnt - base0), 32'd0);
    chk("t5_last_word", mem[511], exp_word(510));
    chk("t5_drop_cnt", 32'(bus.rx_drop_cnt), 32'd2);
    chk("t5_rxfull", 32'(bus.rxfull), 32'd0);

    // Foreign unicast DA, then broadcast DA
    build(60, 48'h0200_0000_0002, -1, 0, 3'b000);
    base0 = addr0_cnt;
    drive(1, 100000, 0);
`ifdef MAC_RX_ADDR_FILTER_EN
    repeat (5) step();
    chk("t6_no_status", 32'(addr0_cnt - base0), 32'd0);
    chk("t6_rxfull", 32'(bus.rxfull), 32'd0);
`else
    wait_full("t6_rxfull");
    chk("t6_status", mem[0], 32'h0001_003C);
    ack("t6_ack");
`endif
    build(60, 48'hFFFF_FFFF_FFFF, -1, 0, 3'b000);
    drive(1, 100000, 0);
    wait_full("t6_bcast_rxfull");
    chk("t6_bcast_status", mem[0], 32'h0001_003C);
    chk("t6_drop_cnt", 32'(bus.rx_drop_cnt), 32'(DROPS_T6));
    ack("t6_bcast_ack");

    // Reset in the middle of a frame, then a clean frame ending on its last strobe
    build(60, STA, -1, 0, 3'b000);
    drive(1, 200, 2);
    rst_i = 1'b0;
    bus.rx_dv = 1'b0;
    step();
    chk("t7_rst_rxfull", 32'(bus.rxfull), 32'd0);
    chk("t7_rst_drop_cnt", 32'(bus.rx_drop_cnt), 32'd0);
    chk("t7_rst_buf_we", 32'(bus.buf_we), 32'd0);
    rst_i = 1'b1;
    step();
    base = wr_cnt;
    drive(1, 100000, 1);
    wait_full("t7_rxfull");
    chk("t7_writes", 32'(wr_cnt - base), 32'd17);
    chk("t7_last_word", mem[16], exp_word(15));
    chk("t7_status", mem[0], 32'h0001_003C);
    ack("t7_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
